fifo_rr_arbiter: RTL

//  Shares the 8-entry FIFO between two requesters (A, B), each issuing write or read ops.

---
 rtl/fifo_rr_arbiter_if.sv | 21 ++
 rtl/fifo_rr_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: requester handshakes plus FIFO control/status bundle
interface fifo_rr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 4
);
  logic                  a_req, a_rw, a_ack, a_err;
  logic [DATA_WIDTH-1:0] a_din, a_dout;
  logic                  b_req, b_rw, b_ack, b_err;
  logic [DATA_WIDTH-1:0] b_din, b_dout;
  logic                  f_wr_en, f_rd_en, f_full, f_empty;
  logic [DATA_WIDTH-1:0] f_din, f_dout;
  logic [CNT_WIDTH-1:0]  f_data_count;
  modport master (
    output a_req, a_rw, a_din, b_req, b_rw, b_din, f_dout, f_full, f_empty, f_data_count,
    input  a_ack, a_err, a_dout, b_ack, b_err, b_dout, f_wr_en, f_rd_en, f_din
  );
  modport slave (
    input  a_req, a_rw, a_din, b_req, b_rw, b_din, f_dout, f_full, f_empty, f_data_count,
    output a_ack, a_err, a_dout, b_ack, b_err, b_dout, f_wr_en, f_rd_en, f_din
  );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin arbiter sharing one FIFO between two op requesters
module fifo_rr_arbiter (
  input logic              clk,
  input logic              reset,
  fifo_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, RESP = 2'b10} state_t;
  state_t state;
  logic win, last, rw, a_fwd, b_fwd, pick_b, pick_rw, reject;
  logic [$bits(bus.a_dout)-1:0] a_hold, b_hold;
  logic unused_count;
  assign unused_count = ^bus.f_data_count;
  assign pick_b  = bus.b_req & (~bus.a_req | ~last);
  assign pick_rw = pick_b ? bus.b_rw : bus.a_rw;
  assign reject  = pick_rw ? bus.f_full : bus.f_empty;
  // FIFO read data lands during the ack cycle: forward it then, hold it afterwards
  assign bus.a_dout = a_fwd ? bus.f_dout : a_hold;
  assign bus.b_dout = b_fwd ? bus.f_dout : b_hold;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      win         <= 1'b0;
      last        <= 1'b1;
      rw          <= 1'b0;
      a_fwd       <= 1'b0;
      b_fwd       <= 1'b0;
      a_hold      <= '0;
      b_hold      <= '0;
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_err   <= 1'b0;
      bus.b_err   <= 1'b0;
      bus.f_wr_en <= 1'b0;
      bus.f_rd_en <= 1'b0;
      bus.f_din   <= '0;
    end else begin
      bus.a_ack   <= 1'b0;
      bus.b_ack   <= 1'b0;
      bus.a_err   <= 1'b0;
      bus.b_err   <= 1'b0;
      bus.f_wr_en <= 1'b0;
      bus.f_rd_en <= 1'b0;
      a_fwd       <= 1'b0;
      b_fwd       <= 1'b0;
      if (a_fwd) a_hold <= bus.f_dout;
      if (b_fwd) b_hold <= bus.f_dout;
      case (state)
        IDLE: if (bus.a_req | bus.b_req) begin
          win <= pick_b;
          rw  <= pick_rw;
          if (reject) begin
            state     <= RESP;
            bus.a_ack <= ~pick_b;
            bus.b_ack <= pick_b;
            bus.a_err <= ~pick_b;
            bus.b_err <= pick_b;
          end else begin
            state       <= ISSUE;
            bus.f_wr_en <= pick_rw;
            bus.f_rd_en <= ~pick_rw;
            bus.f_din   <= pick_b ? bus.b_din : bus.a_din;
          end
        end
        ISSUE: begin
          state     <= RESP;
          bus.a_ack <= ~win;
          bus.b_ack <= win;
          a_fwd     <= ~win & ~rw;
          b_fwd     <= win & ~rw;
        end
        RESP: begin
          state <= IDLE;
          last  <= win;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
